m68k_uart_bridge: RTL and testbench
===================================

# m68k_uart_bridge

Parametrised bus-cycle-to-UART bridge for the m68k FPGA tester, clocked in the `clk_sys` domain. It sits between the already-synchronised 68000 bus samples and the AVR UART byte interface. For each bus cycle it transmits a framed record (direction, strobes, FC, address, and write data when the cycle is a write). It then terminates the cycle with DTACK or BERR from host commands, or automatically with BERR after a configurable timeout.

## Interface
- `ADDR_WIDTH`, default 24: address bits forwarded. Must be a multiple of 8, range 8..32; address is sent as ADDR_WIDTH/8 bytes.
- `TIMEOUT`, default 1000000: `clk_sys` cycles spent in WAIT_RESP before auto-BERR. 0 disables the timeout.
- `clk_sys` input 1: system clock. All logic is on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `as` input 1: synchronised address strobe, active-high.
- `uds`, `lds` input 1 each: synchronised data strobes, active-high.
- `rw` input 1: 1 = read, 0 = write.
- `fc` input 3: function code.
- `a` input ADDR_WIDTH: address.
- `d_in` input 16: bus data, used for writes.
- `tx_data` output 8: byte to UART.
- `new_tx_data` output 1: byte valid.
- `tx_busy` input 1: UART cannot accept.
- `rx_data` input 8: received byte.
- `new_rx_data` input 1: one-cycle rx valid.
- `d_out` output 16: read data buffer.
- `dtack` output 1: terminate OK, active-high.
- `berr` output 1: terminate with bus error, active-high.
- `cycle_active` output 1: 1 whenever state is not IDLE.

## Operation
- **Start condition:** in IDLE, the first cycle with `as & (uds | lds)`. On that cycle latch `rw`, `uds`, `lds`, `fc`, `a` and `d_in`, then go to SEND.
- **Frame, in order:**
  - byte 0: 0x52 ('R') for a read, 0x57 ('W') for a write.
  - byte 1: {rw, uds, lds, 2'b00, fc}.
  - address bytes, MSB first.
  - writes only: d_in[15:8], then d_in[7:0].
- **Frame length:** 2 + ADDR_WIDTH/8 bytes for a read, plus 2 for a write.
- **SEND:** a byte is accepted on a cycle where `new_tx_data & ~tx_busy`. After the last byte is accepted, go to WAIT_RESP and clear the timeout counter.
- **Rx parser:** runs in every state, including IDLE and SEND.
  - 'B' (0x42): the next two bytes load d_out[7:0], then d_out[15:8].
  - 'L' (0x4C): the next byte loads d_out[7:0].
  - 'H' (0x48): the next byte loads d_out[15:8].
  - Any other byte in parser-idle is ignored, except as listed below.
- **Termination commands:** 'D' (0x44) and 'E' (0x45) are acted on only in WAIT_RESP with the parser idle. Everywhere else they are discarded.
  - 'D': set `dtack`, go to TERM.
  - 'E': set `berr`, go to TERM.
- **Timeout:** counter increments each cycle in WAIT_RESP. On reaching TIMEOUT: set `berr`, queue byte 0x54 ('T') for transmission, go to TERM.
- **TERM:** hold `dtack`/`berr` and send any queued 'T'. When `as` deasserts, clear both, go to IDLE.
- **Abort:** `as` deasserting in SEND or WAIT_RESP clears `dtack`, `berr` and the queued bytes, then go to IDLE next cycle.
  - A byte already accepted by the UART is not recalled.
  - `new_tx_data` drops on the following cycle.
- **d_out:** retained across cycles; changed only by the rx parser or reset.
- **Reset:** `tx_data`=0, `new_tx_data`=0, `d_out`=0, `dtack`=0, `berr`=0, `cycle_active`=0, state IDLE, parser idle, counter 0.

## Timing
- Start detected at cycle N: `new_tx_data`=1 with byte 0 at N+1.
- Holding rule: `tx_data` and `new_tx_data` stay stable while `tx_busy`=1.
- The next byte is presented on the cycle after acceptance, at the earliest.
- 'D'/'E' accepted at cycle M → `dtack`/`berr` high at M+1.
- Timeout: `berr` high exactly TIMEOUT cycles after WAIT_RESP entry.
- Simultaneous events:
  - 'D'/'E' on the same cycle the counter expires: the command wins; no 'T' is sent.
  - `as` deassert on the same cycle as 'D'/'E', or as expiry: deassert wins, go to IDLE, no termination asserted.
- `dtack` and `berr` are never both 1.
- Reset mid-frame: all outputs take reset values asynchronously; no partial byte is re-sent.

## Test plan
- **Read, ADDR_WIDTH=24:** a=0x00ABCE, fc=5, uds=lds=1, rw=1, tx_busy=0.
  - TX stream must be 0x52, 0xE5, 0x00, 0xAB, 0xCE.
  - Then rx 'B', 0x34, 0x12, 'D' → d_out=0x1234 and dtack=1 one cycle after 'D'.
  - Drop as → dtack=0 and IDLE next cycle.
- **Byte write:** a=0x001000, fc=1, rw=0, lds=1, uds=0, d_in=0x00A5.
  - TX must be 0x57, 0x21, 0x00, 0x10, 0x00, 0x00, 0xA5.
  - Rx 'E' → berr=1, dtack stays 0.
- **Backpressure:** hold tx_busy=1 for 10 cycles during byte 2 → tx_data and new_tx_data stay constant; byte 3 appears the cycle after acceptance.
- **Timeout:** TIMEOUT=100, no response → berr rises exactly 100 cycles after WAIT_RESP entry, then 0x54 is transmitted.
  - Repeat with 'D' on the expiry cycle → dtack=1, berr=0, no 0x54.
- **Abort and misplaced commands:** deassert as after byte 1 → remaining bytes not sent and state returns to IDLE.
  - Then send 'D' in IDLE → dtack stays 0.
  - Then send 'L', 0x77 in IDLE → d_out[7:0]=0x77.
- **Async reset mid-WAIT_RESP:** pulse rst_n low asynchronously → all outputs zero immediately.
  - After release, a new read frame is sent correctly.

Source files
------------

// File: rtl/m68k_uart_bridge_if.sv
`default_nettype none
// ============================================================================
// Module  : m68k_uart_bridge_if
// Brief   : 68000 bus-sample and UART byte signals seen by the bridge.
// Revision: 1.0  initial release
// ============================================================================
interface m68k_uart_bridge_if #(
   parameter int ADDR_WIDTH = 24
);
   logic                  as;
   logic                  uds;
   logic                  lds;
   logic                  rw;
   logic [2:0]            fc;
   logic [ADDR_WIDTH-1:0] a;
   logic [15:0]           d_in;
   logic [7:0]            tx_data;
   logic                  new_tx_data;
   logic                  tx_busy;
   logic [7:0]            rx_data;
   logic                  new_rx_data;
   logic [15:0]           d_out;
   logic                  dtack;
   logic                  berr;
   logic                  cycle_active;

   modport slave (
      input  as, uds, lds, rw, fc, a, d_in, tx_busy, rx_data, new_rx_data,
      output tx_data, new_tx_data, d_out, dtack, berr, cycle_active
   );

   modport master (
      output as, uds, lds, rw, fc, a, d_in, tx_busy, rx_data, new_rx_data,
      input  tx_data, new_tx_data, d_out, dtack, berr, cycle_active
   );
endinterface
`default_nettype wire

// File: rtl/m68k_uart_bridge.sv
`default_nettype none
// ============================================================================
// Module  : m68k_uart_bridge
// Brief   : Frames each 68000 bus cycle onto the UART and terminates it from
//           host commands or an auto-BERR timeout.
// Revision: 1.0  initial release
// ============================================================================
module m68k_uart_bridge #(
   parameter int ADDR_WIDTH = 24,
   parameter int TIMEOUT    = 1000000
) (
   input  logic              clk_sys,
   input  logic              rst_n,
   m68k_uart_bridge_if.slave bus
);
   localparam int c_nab = ADDR_WIDTH / 8;
   localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [3:0] c_last_rd = 4'(c_nab + 1);
   localparam logic [3:0] c_last_wr = 4'(c_nab + 3);
   localparam logic [7:0] c_ch_r = 8'h52;
   localparam logic [7:0] c_ch_w = 8'h57;
   localparam logic [7:0] c_ch_b = 8'h42;
   localparam logic [7:0] c_ch_l = 8'h4C;
   localparam logic [7:0] c_ch_h = 8'h48;
   localparam logic [7:0] c_ch_d = 8'h44;
   localparam logic [7:0] c_ch_e = 8'h45;
   localparam logic [7:0] c_ch_t = 8'h54;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_WAIT_RESP = 2'd2, ST_TERM = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      PS_IDLE = 3'd0, PS_BLO = 3'd1, PS_BHI = 3'd2, PS_LO = 3'd3, PS_HI = 3'd4
   } pstate_t;

   state_t                state_q, state_d;
   pstate_t               pstate_q, pstate_d;
   logic                  rw_q, rw_d, uds_q, uds_d, lds_q, lds_d;
   logic [2:0]            fc_q, fc_d;
   logic [ADDR_WIDTH-1:0] a_q, a_d;
   logic [15:0]           wd_q, wd_d;
   logic [3:0]            idx_q, idx_d;
   logic [c_cnt_w-1:0]    cnt_q, cnt_d;
   logic [7:0]            tx_data_q, tx_data_d;
   logic                  new_tx_q, new_tx_d;
   logic [15:0]           d_out_q, d_out_d;
   logic                  dtack_q, dtack_d, berr_q, berr_d;
   logic                  active_q, active_d;

   logic                  w_accept, w_cmd_d, w_cmd_e;
   logic [3:0]            w_last;

   // Byte idx of the frame: marker, flags, address MSB first, then write data.
   function automatic logic [7:0] frame_byte(
      input logic [3:0] idx, input logic rw, input logic uds, input logic lds,
      input logic [2:0] fc, input logic [ADDR_WIDTH-1:0] a, input logic [15:0] d
   );
      logic [7:0] b;
      b = 8'h00;
      if (idx == 4'd0)                    b = rw ? c_ch_r : c_ch_w;
      else if (idx == 4'd1)               b = {rw, uds, lds, 2'b00, fc};
      else if (idx == c_last_wr - 4'd1)   b = d[15:8];
      else if (idx == c_last_wr)          b = d[7:0];
      for (int k = 0; k < c_nab; k++) begin
         if (idx == 4'(k + 2)) b = a[ADDR_WIDTH-1-8*k -: 8];
      end
      return b;
   endfunction

   assign w_accept = new_tx_q && !bus.tx_busy;
   assign w_cmd_d  = bus.new_rx_data && (pstate_q == PS_IDLE) && (bus.rx_data == c_ch_d);
   assign w_cmd_e  = bus.new_rx_data && (pstate_q == PS_IDLE) && (bus.rx_data == c_ch_e);
   assign w_last   = rw_q ? c_last_rd : c_last_wr;

   always_comb begin
      state_d   = state_q;
      pstate_d  = pstate_q;
      rw_d      = rw_q;
      uds_d     = uds_q;
      lds_d     = lds_q;
      fc_d      = fc_q;
      a_d       = a_q;
      wd_d      = wd_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      tx_data_d = tx_data_q;
      new_tx_d  = new_tx_q;
      d_out_d   = d_out_q;
      dtack_d   = dtack_q;
      berr_d    = berr_q;

      // The rx parser is independent of the bus-cycle state.
      if (bus.new_rx_data) begin
         case (pstate_q)
            PS_IDLE: begin
               if (bus.rx_data == c_ch_b)      pstate_d = PS_BLO;
               else if (bus.rx_data == c_ch_l) pstate_d = PS_LO;
               else if (bus.rx_data == c_ch_h) pstate_d = PS_HI;
            end
            PS_BLO:  begin d_out_d[7:0]  = bus.rx_data; pstate_d = PS_BHI;  end
            PS_BHI:  begin d_out_d[15:8] = bus.rx_data; pstate_d = PS_IDLE; end
            PS_LO:   begin d_out_d[7:0]  = bus.rx_data; pstate_d = PS_IDLE; end
            PS_HI:   begin d_out_d[15:8] = bus.rx_data; pstate_d = PS_IDLE; end
            default: pstate_d = PS_IDLE;
         endcase
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.as && (bus.uds || bus.lds)) begin
               rw_d      = bus.rw;
               uds_d     = bus.uds;
               lds_d     = bus.lds;
               fc_d      = bus.fc;
               a_d       = bus.a;
               wd_d      = bus.d_in;
               idx_d     = 4'd0;
               tx_data_d = frame_byte(4'd0, bus.rw, bus.uds, bus.lds, bus.fc, bus.a, bus.d_in);
               new_tx_d  = 1'b1;
               state_d   = ST_SEND;
            end
         end
         ST_SEND: begin
            if (!bus.as) begin
               new_tx_d = 1'b0;
               dtack_d  = 1'b0;
               berr_d   = 1'b0;
               state_d  = ST_IDLE;
            end else if (w_accept) begin
               if (idx_q == w_last) begin
                  new_tx_d = 1'b0;
                  cnt_d    = '0;
                  state_d  = ST_WAIT_RESP;
               end else begin
                  idx_d     = idx_q + 4'd1;
                  tx_data_d = frame_byte(idx_q + 4'd1, rw_q, uds_q, lds_q, fc_q, a_q, wd_q);
                  new_tx_d  = 1'b1;
               end
            end
         end
         ST_WAIT_RESP: begin
            // Priority: bus abort, then host command, then timeout expiry.
            if (!bus.as) begin
               new_tx_d = 1'b0;
               dtack_d  = 1'b0;
               berr_d   = 1'b0;
               state_d  = ST_IDLE;
            end else if (w_cmd_d) begin
               dtack_d = 1'b1;
               state_d = ST_TERM;
            end else if (w_cmd_e) begin
               berr_d  = 1'b1;
               state_d = ST_TERM;
            end else if ((TIMEOUT != 0) && (cnt_q == c_cnt_last)) begin
               berr_d    = 1'b1;
               tx_data_d = c_ch_t;
               new_tx_d  = 1'b1;
               state_d   = ST_TERM;
            end else begin
               cnt_d = cnt_q + c_cnt_w'(1);
            end
         end
         ST_TERM: begin
            if (w_accept) new_tx_d = 1'b0;
            if (!bus.as) begin
               new_tx_d = 1'b0;
               dtack_d  = 1'b0;
               berr_d   = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      active_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pstate_q  <= PS_IDLE;
         rw_q      <= 1'b0;
         uds_q     <= 1'b0;
         lds_q     <= 1'b0;
         fc_q      <= 3'd0;
         a_q       <= '0;
         wd_q      <= 16'd0;
         idx_q     <= 4'd0;
         cnt_q     <= '0;
         tx_data_q <= 8'd0;
         new_tx_q  <= 1'b0;
         d_out_q   <= 16'd0;
         dtack_q   <= 1'b0;
         berr_q    <= 1'b0;
         active_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pstate_q  <= pstate_d;
         rw_q      <= rw_d;
         uds_q     <= uds_d;
         lds_q     <= lds_d;
         fc_q      <= fc_d;
         a_q       <= a_d;
         wd_q      <= wd_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         tx_data_q <= tx_data_d;
         new_tx_q  <= new_tx_d;
         d_out_q   <= d_out_d;
         dtack_q   <= dtack_d;
         berr_q    <= berr_d;
         active_q  <= active_d;
      end
   end

   assign bus.tx_data      = tx_data_q;
   assign bus.new_tx_data  = new_tx_q;
   assign bus.d_out        = d_out_q;
   assign bus.dtack        = dtack_q;
   assign bus.berr         = berr_q;
   assign bus.cycle_active = active_q;
endmodule
`default_nettype wire

// File: tb/tb_m68k_uart_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_m68k_uart_bridge
// Brief   : Scoreboard bench for m68k_uart_bridge (24-bit address, TIMEOUT=100).
// Revision: 1.0  initial release
// ============================================================================
module tb_m68k_uart_bridge;
   localparam int AW = 24;
   localparam int TMO = 100;

   logic clk_sys = 1'b0;
   logic rst_n;
   always #5 clk_sys = ~clk_sys;

   m68k_uart_bridge_if #(.ADDR_WIDTH(AW)) bus ();

   m68k_uart_bridge #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   int          n_vec;
   int          n_err;
   logic [7:0]  exp_q[$];
   int          pend[$];
   logic [15:0] d_model;
   bit          in_wait, exp_dt, exp_be;
   bit          busy_mode, busy_req;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Expected UART frame built straight from the field layout.
   function automatic void push_frame(input bit rw, input bit u, input bit l,
                                      input logic [2:0] fc, input logic [AW-1:0] a,
                                      input logic [15:0] d);
      exp_q.push_back(rw ? 8'h52 : 8'h57);
      exp_q.push_back({rw, u, l, 2'b00, fc});
      for (int i = AW / 8 - 1; i >= 0; i--) exp_q.push_back(a[i*8 +: 8]);
      if (!rw) begin
         exp_q.push_back(d[15:8]);
         exp_q.push_back(d[7:0]);
      end
   endfunction

   task automatic monitor();
      bit         hold_prev = 1'b0;
      logic [7:0] hold_byte = 8'h00;
      logic [7:0] e;
      forever begin
         @(negedge clk_sys);
         if (!rst_n) begin
            hold_prev = 1'b0;
         end else begin
            if (hold_prev) begin
               chk("tx_hold_valid", bus.new_tx_data, 1);
               chk("tx_hold_data", bus.tx_data, hold_byte);
            end
            chk("term_exclusive", bus.dtack & bus.berr, 0);
            if (bus.new_tx_data && !bus.tx_busy) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL tx_unexpected: got byte %02h expected none at %0t", bus.tx_data, $time);
               end else begin
                  e = exp_q.pop_front();
                  chk("tx_byte", bus.tx_data, e);
               end
            end
            hold_prev = bus.new_tx_data && bus.tx_busy && bus.as;
            hold_byte = bus.tx_data;
         end
      end
   endtask

   task automatic busy_driver();
      forever begin
         @(posedge clk_sys);
         #2;
         bus.tx_busy = busy_mode ? ($urandom_range(0, 2) == 0) : busy_req;
      end
   endtask

   task automatic start_cycle(input bit rw, input bit u, input bit l, input logic [2:0] fc,
                              input logic [AW-1:0] a, input logic [15:0] d);
      push_frame(rw, u, l, fc, a, d);
      bus.rw = rw; bus.uds = u; bus.lds = l; bus.fc = fc; bus.a = a; bus.d_in = d;
      bus.as = 1'b1;
      tick();
      chk("first_byte_valid", bus.new_tx_data, 1);
      chk("first_byte_data", bus.tx_data, rw ? 8'h52 : 8'h57);
      chk("cycle_active_on", bus.cycle_active, 1);
   endtask

   task automatic wait_frame();
      int k = 0;
      while (exp_q.size() != 0 && k < 400) begin
         tick();
         k++;
      end
      chk("frame_drained", exp_q.size(), 0);
      in_wait = 1'b1;
   endtask

   task automatic send_rx(input logic [7:0] b);
      int t;
      bus.rx_data = b;
      bus.new_rx_data = 1'b1;
      tick();
      bus.new_rx_data = 1'b0;
      if (pend.size() != 0) begin
         t = pend.pop_front();
         if (t == 0) d_model[7:0] = b;
         else        d_model[15:8] = b;
      end else if (b == 8'h42) begin
         pend.push_back(0); pend.push_back(1);
      end else if (b == 8'h4C) begin
         pend.push_back(0);
      end else if (b == 8'h48) begin
         pend.push_back(1);
      end else if (in_wait && (b == 8'h44 || b == 8'h45)) begin
         exp_dt = (b == 8'h44);
         exp_be = (b == 8'h45);
         in_wait = 1'b0;
      end
      chk("d_out", bus.d_out, d_model);
      chk("dtack", bus.dtack, exp_dt);
      chk("berr", bus.berr, exp_be);
   endtask

   task automatic drop_as();
      bus.as = 1'b0; bus.uds = 1'b0; bus.lds = 1'b0;
      tick();
      in_wait = 1'b0; exp_dt = 1'b0; exp_be = 1'b0;
      chk("drop_dtack", bus.dtack, 0);
      chk("drop_berr", bus.berr, 0);
      chk("drop_idle", bus.cycle_active, 0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_tx_data"}, bus.tx_data, 0);
      chk({tag, "_new_tx"}, bus.new_tx_data, 0);
      chk({tag, "_d_out"}, bus.d_out, 0);
      chk({tag, "_dtack"}, bus.dtack, 0);
      chk({tag, "_berr"}, bus.berr, 0);
      chk({tag, "_active"}, bus.cycle_active, 0);
   endtask

   initial begin
      int k;
      logic [1:0] s;
      n_vec = 0; n_err = 0; d_model = 16'h0;
      in_wait = 1'b0; exp_dt = 1'b0; exp_be = 1'b0;
      busy_mode = 1'b0; busy_req = 1'b0;
      rst_n = 1'b0;
      bus.as = 1'b0; bus.uds = 1'b0; bus.lds = 1'b0; bus.rw = 1'b1; bus.fc = 3'd0;
      bus.a = '0; bus.d_in = 16'h0; bus.rx_data = 8'h0; bus.new_rx_data = 1'b0;
      bus.tx_busy = 1'b0;
      fork
         monitor();
         busy_driver();
         begin
            #3000000;
            $display("FAIL watchdog: got no finish expected finish before time limit");
            $fatal(1);
         end
      join_none

      repeat (3) @(posedge clk_sys);
      #1;
      check_zero("reset");
      @(negedge clk_sys);
      rst_n = 1'b1;
      tick();

      // Read cycle answered with 'B' data and 'D'.
      start_cycle(1'b1, 1'b1, 1'b1, 3'd5, 24'h00ABCE, 16'h0);
      wait_frame();
      send_rx(8'h42); send_rx(8'h34); send_rx(8'h12);
      chk("read_dout", bus.d_out, 16'h1234);
      send_rx(8'h44);
      drop_as();

      // Byte write terminated with 'E'.
      start_cycle(1'b0, 1'b0, 1'b1, 3'd1, 24'h001000, 16'h00A5);
      wait_frame();
      send_rx(8'h45);
      drop_as();

      // Backpressure on address MSB byte.
      start_cycle(1'b1, 1'b1, 1'b0, 3'd2, 24'hC31122, 16'h0);
      k = 0;
      while (!(bus.new_tx_data && bus.tx_data == 8'hC3) && k < 20) begin
         tick();
         k++;
      end
      busy_req = 1'b1;
      repeat (10) tick();
      chk("bp_hold_valid", bus.new_tx_data, 1);
      chk("bp_hold_data", bus.tx_data, 8'hC3);
      busy_req = 1'b0;
      tick();
      chk("bp_next_valid", bus.new_tx_data, 1);
      chk("bp_next_data", bus.tx_data, 8'h11);
      wait_frame();
      send_rx(8'h44);
      drop_as();

      // Timeout with no response.
      start_cycle(1'b1, 1'b1, 1'b1, 3'd6, 24'h0F0E0D, 16'h0);
      wait_frame();
      exp_q.push_back(8'h54);
      k = 0;
      while (!bus.berr && k < 200) begin
         tick();
         k++;
      end
      chk("timeout_latency", k, TMO);
      chk("timeout_dtack", bus.dtack, 0);
      repeat (2) tick();
      chk("timeout_t_sent", exp_q.size(), 0);
      in_wait = 1'b0; exp_be = 1'b1;
      drop_as();

      // 'D' on the expiry cycle wins and suppresses 'T'.
      start_cycle(1'b1, 1'b0, 1'b1, 3'd3, 24'h445566, 16'h0);
      wait_frame();
      repeat (TMO - 1) tick();
      send_rx(8'h44);
      repeat (5) tick();
      chk("expiry_no_t", bus.new_tx_data, 0);
      chk("expiry_berr", bus.berr, 0);
      drop_as();

      // Abort after byte 1, then misplaced commands in IDLE.
      start_cycle(1'b0, 1'b1, 1'b1, 3'd7, 24'h123456, 16'hBEEF);
      tick();
      tick();
      busy_req = 1'b1;
      bus.as = 1'b0; bus.uds = 1'b0; bus.lds = 1'b0;
      exp_q.delete();
      tick();
      chk("abort_new_tx", bus.new_tx_data, 0);
      chk("abort_idle", bus.cycle_active, 0);
      busy_req = 1'b0;
      repeat (5) tick();
      in_wait = 1'b0;
      send_rx(8'h44);
      send_rx(8'h4C); send_rx(8'h77);
      chk("idle_l_dout", bus.d_out[7:0], 8'h77);

      // Asynchronous reset while waiting for a response.
      start_cycle(1'b1, 1'b1, 1'b1, 3'd4, 24'h654321, 16'h0);
      wait_frame();
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("async_rst");
      bus.as = 1'b0; bus.uds = 1'b0; bus.lds = 1'b0;
      in_wait = 1'b0; d_model = 16'h0; pend.delete();
      @(negedge clk_sys);
      rst_n = 1'b1;
      tick();
      start_cycle(1'b1, 1'b1, 1'b1, 3'd0, 24'hFEDCBA, 16'h0);
      wait_frame();
      send_rx(8'h44);
      drop_as();

      // Randomised cycles with random UART backpressure.
      busy_mode = 1'b1;
      for (int it = 0; it < 40; it++) begin
         send_rx(8'($urandom_range(0, 255)));
         s = 2'($urandom_range(1, 3));
         start_cycle(1'($urandom), s[1], s[0], 3'($urandom), AW'($urandom), 16'($urandom));
         wait_frame();
         case ($urandom_range(0, 3))
            1: begin send_rx(8'h42); send_rx(8'($urandom)); send_rx(8'($urandom)); end
            2: begin send_rx(8'h4C); send_rx(8'($urandom)); end
            3: begin send_rx(8'h48); send_rx(8'($urandom)); end
            default: ;
         endcase
         send_rx(($urandom_range(0, 1) == 1) ? 8'h44 : 8'h45);
         drop_as();
      end
      busy_mode = 1'b0;
      repeat (5) tick();
      chk("final_queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
